// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// In-order retirement buffer for an out-of-order core. The rename stage
// allocates entries at the tail. Execution units mark entries done by index,
// and branch units also record a mispredict flag and a redirect target.
// Entries retire from the head, one per cycle, once they are done. When a
// mispredicted branch retires, the next cycle is a one-cycle recovery pulse:
//   - every entry is discarded;
//   - tail snaps back to head;
//   - recovery_pc carries the branch target.
//
// Optional feature (compile-time macro ROB_WB_BYPASS_EN):
//   defined   -> a write-back or branch resolution aimed at the current head
//                counts as done in the same cycle, so the head can retire in
//                the cycle of its write-back.
//   undefined -> done is taken only from the stored bit, so retirement
//                happens one cycle after write-back.
//
// Parameters
//   DEPTH                  number of entries (power of two, >= 2)
//
// Ports
//   clk                    clock, rising edge
//   rst                    asynchronous reset, active low
//   alloc_valid/ready      allocation handshake from rename
//   alloc_wb_en            instruction writes a destination register
//   alloc_A_rd             architectural destination register
//   alloc_P_rd_new         newly mapped physical register
//   alloc_P_rd_old         previously mapped physical register
//   alloc_idx              index given to the allocating instruction (tail)
//   wb_valid/wb_idx        execution complete for an entry
//   br_valid/br_idx        branch resolved for an entry
//   br_mispredict          branch was mispredicted
//   br_target              redirect target for a mispredicted branch
//   commit_valid           head entry retires this cycle
//   commit_wb_en           retiring entry writes a destination
//   commit_A_rd            architectural rd of the retiring entry (0 when idle)
//   commit_P_rd_new        new physical rd of the retiring entry (0 when idle)
//   commit_P_rd_old        old physical rd of the retiring entry (0 when idle)
//   recovery               registered flush pulse
//   recovery_pc            redirect target that goes with the flush pulse
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_valid,
  output logic                     alloc_ready,
  input  logic                     alloc_wb_en,
  input  logic [5:0]               alloc_A_rd,
  input  logic [6:0]               alloc_P_rd_new,
  input  logic [6:0]               alloc_P_rd_old,
  output logic [$clog2(DEPTH)-1:0] alloc_idx,
  input  logic                     wb_valid,
  input  logic [$clog2(DEPTH)-1:0] wb_idx,
  input  logic                     br_valid,
  input  logic [$clog2(DEPTH)-1:0] br_idx,
  input  logic                     br_mispredict,
  input  logic [31:0]              br_target,
  output logic                     commit_valid,
  output logic                     commit_wb_en,
  output logic [5:0]               commit_A_rd,
  output logic [6:0]               commit_P_rd_new,
  output logic [6:0]               commit_P_rd_old,
  output logic                     recovery,
  output logic [31:0]              recovery_pc
);

  localparam int IW = $clog2(DEPTH);

  // Control state (reset)
  logic [IW:0]       head_q, head_d, tail_q, tail_d;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d, mis_q, mis_d;
  logic              recovery_q, recovery_d;
  logic [31:0]       recovery_pc_q, recovery_pc_d;

  // Entry payload (not reset; only read while the entry is valid)
  logic [5:0]        a_rd_q  [DEPTH];
  logic [6:0]        p_new_q [DEPTH];
  logic [6:0]        p_old_q [DEPTH];
  logic              wben_q  [DEPTH];
  logic [31:0]       tgt_q   [DEPTH];

  logic [IW-1:0]     head_idx, tail_idx;
  logic              full;
  logic              head_done, head_mis;
  logic [31:0]       head_tgt;
  logic              flush_pending;
  logic              alloc_fire;

  assign head_idx = head_q[IW-1:0];
  assign tail_idx = tail_q[IW-1:0];
  assign full     = (head_q[IW] != tail_q[IW]) && (head_idx == tail_idx);

`ifdef ROB_WB_BYPASS_EN
  logic wb_hit_head, br_hit_head;
  assign wb_hit_head = wb_valid && (wb_idx == head_idx);
  assign br_hit_head = br_valid && (br_idx == head_idx);
  assign head_done   = done_q[head_idx] || wb_hit_head || br_hit_head;
  assign head_mis    = br_hit_head ? br_mispredict : mis_q[head_idx];
  assign head_tgt    = br_hit_head ? br_target     : tgt_q[head_idx];
`else
  assign head_done   = done_q[head_idx];
  assign head_mis    = mis_q[head_idx];
  assign head_tgt    = tgt_q[head_idx];
`endif

  assign commit_valid  = valid_q[head_idx] && head_done && !recovery_q;
  // A retiring mispredict blocks allocation: tail is about to be rewound.
  assign flush_pending = commit_valid && head_mis;
  assign alloc_ready   = !full && !recovery_q && !flush_pending;
  assign alloc_fire    = alloc_valid && alloc_ready;
  assign alloc_idx     = tail_idx;

  assign commit_wb_en    = commit_valid && wben_q[head_idx];
  assign commit_A_rd     = commit_valid ? a_rd_q[head_idx]  : 6'd0;
  assign commit_P_rd_new = commit_valid ? p_new_q[head_idx] : 7'd0;
  assign commit_P_rd_old = commit_valid ? p_old_q[head_idx] : 7'd0;
  assign recovery        = recovery_q;
  assign recovery_pc     = recovery_pc_q;

  always_comb begin
    head_d        = head_q;
    tail_d        = tail_q;
    valid_d       = valid_q;
    done_d        = done_q;
    mis_d         = mis_q;
    recovery_d    = 1'b0;
    recovery_pc_d = recovery_pc_q;
    if (recovery_q) begin
      // Flush cycle: drop everything younger than the retired branch.
      valid_d = '0;
      done_d  = '0;
      mis_d   = '0;
      tail_d  = head_q;
    end else begin
      if (wb_valid && valid_q[wb_idx]) begin
        done_d[wb_idx] = 1'b1;
      end
      if (br_valid && valid_q[br_idx]) begin
        done_d[br_idx] = 1'b1;
        mis_d[br_idx]  = br_mispredict;
      end
      if (commit_valid) begin
        valid_d[head_idx] = 1'b0;
        head_d            = head_q + 1'b1;
        if (flush_pending) begin
          recovery_d    = 1'b1;
          recovery_pc_d = head_tgt;
        end
      end
      // Allocation last: the new entry starts clean even if it reuses a slot.
      if (alloc_fire) begin
        valid_d[tail_idx] = 1'b1;
        done_d[tail_idx]  = 1'b0;
        mis_d[tail_idx]   = 1'b0;
        tail_d            = tail_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q        <= '0;
      tail_q        <= '0;
      valid_q       <= '0;
      done_q        <= '0;
      mis_q         <= '0;
      recovery_q    <= 1'b0;
      recovery_pc_q <= '0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      valid_q       <= valid_d;
      done_q        <= done_d;
      mis_q         <= mis_d;
      recovery_q    <= recovery_d;
      recovery_pc_q <= recovery_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      a_rd_q[tail_idx]  <= alloc_A_rd;
      p_new_q[tail_idx] <= alloc_P_rd_new;
      p_old_q[tail_idx] <= alloc_P_rd_old;
      wben_q[tail_idx]  <= alloc_wb_en;
    end
    if (!recovery_q && br_valid && valid_q[br_idx]) begin
      tgt_q[br_idx] <= br_target;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int IW    = $clog2(DEPTH);
`ifdef ROB_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_valid, alloc_ready, alloc_wb_en;
  logic [5:0]    alloc_A_rd;
  logic [6:0]    alloc_P_rd_new, alloc_P_rd_old;
  logic [IW-1:0] alloc_idx;
  logic          wb_valid;
  logic [IW-1:0] wb_idx;
  logic          br_valid;
  logic [IW-1:0] br_idx;
  logic          br_mispredict;
  logic [31:0]   br_target;
  logic          commit_valid, commit_wb_en;
  logic [5:0]    commit_A_rd;
  logic [6:0]    commit_P_rd_new, commit_P_rd_old;
  logic          recovery;
  logic [31:0]   recovery_pc;

  reorder_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_wb_en(alloc_wb_en),
    .alloc_A_rd(alloc_A_rd), .alloc_P_rd_new(alloc_P_rd_new), .alloc_P_rd_old(alloc_P_rd_old),
    .alloc_idx(alloc_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx),
    .br_valid(br_valid), .br_idx(br_idx), .br_mispredict(br_mispredict), .br_target(br_target),
    .commit_valid(commit_valid), .commit_wb_en(commit_wb_en), .commit_A_rd(commit_A_rd),
    .commit_P_rd_new(commit_P_rd_new), .commit_P_rd_old(commit_P_rd_old),
    .recovery(recovery), .recovery_pc(recovery_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0] a;
    logic [6:0] pn;
    logic [6:0] po;
    logic       we;
  } rec_t;

  typedef struct {
    logic [5:0] a;
    logic [6:0] pn;
    logic [6:0] po;
    logic       we;
    logic       exp_wb;
  } vec_t;

  rec_t        sb[$];
  int          pass_cnt = 0;
  int          chk_cnt  = 0;
  int          commit_cnt = 0;
  int          exp_head = 0;
  int          exp_tail = 0;
  logic [31:0] exp_rpc  = 32'h0;
  bit          mon_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  task automatic idle();
    alloc_valid = 0; alloc_wb_en = 0; alloc_A_rd = 0; alloc_P_rd_new = 0; alloc_P_rd_old = 0;
    wb_valid = 0; wb_idx = 0; br_valid = 0; br_idx = 0; br_mispredict = 0; br_target = 0;
  endtask

  task automatic nxt();
    @(posedge clk); #1; idle();
  endtask

  task automatic smp();
    @(negedge clk); #1;
  endtask

  task automatic set_alloc(input int a, input int pn, input int po, input bit we);
    alloc_valid = 1; alloc_A_rd = 6'(a); alloc_P_rd_new = 7'(pn); alloc_P_rd_old = 7'(po);
    alloc_wb_en = we;
  endtask

  task automatic drain();
    for (int k = 0; k < 40; k++) begin
      if (sb.size() == 0) break;
      smp(); nxt();
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard: accepted allocations pushed, retirements popped in order.
  always @(negedge clk) begin
    if (rst && mon_en) begin
      if (recovery) begin
        chk("rec_commit_valid", 32'(commit_valid), 32'd0);
        chk("rec_commit_wb_en", 32'(commit_wb_en), 32'd0);
        chk("rec_pc", recovery_pc, exp_rpc);
        chk("rec_alloc_ready", 32'(alloc_ready), 32'd0);
        sb.delete();
        exp_tail = exp_head;
      end else if (commit_valid) begin
        if (sb.size() == 0) begin
          chk("commit_unexpected", 32'(commit_valid), 32'd0);
        end else begin
          rec_t r;
          r = sb.pop_front();
          chk("sb_A_rd", 32'(commit_A_rd), 32'(r.a));
          chk("sb_P_new", 32'(commit_P_rd_new), 32'(r.pn));
          chk("sb_P_old", 32'(commit_P_rd_old), 32'(r.po));
          chk("sb_wb_en", 32'(commit_wb_en), 32'(r.we));
        end
        commit_cnt++;
        exp_head++;
      end
      if (alloc_valid && alloc_ready) begin
        rec_t r;
        chk("sb_alloc_idx", 32'(alloc_idx), 32'(exp_tail % DEPTH));
        r.a = alloc_A_rd; r.pn = alloc_P_rd_new; r.po = alloc_P_rd_old; r.we = alloc_wb_en;
        sb.push_back(r);
        exp_tail++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[4];
    int   h0, c0, s, ix;
    bit   seen;

    vecs[0] = '{6'd5,  7'd64,  7'd5,   1'b1, 1'b1};
    vecs[1] = '{6'd0,  7'd0,   7'd0,   1'b0, 1'b0};
    vecs[2] = '{6'd63, 7'd127, 7'd126, 1'b1, 1'b1};
    vecs[3] = '{6'd17, 7'd3,   7'd100, 1'b0, 1'b0};

    idle();
    rst = 0;
    repeat (3) @(posedge clk);
    smp();
    chk("rst_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rst_alloc_idx", 32'(alloc_idx), 32'd0);
    chk("rst_commit_valid", 32'(commit_valid), 32'd0);
    chk("rst_commit_wb_en", 32'(commit_wb_en), 32'd0);
    chk("rst_commit_fields", {13'd0, commit_A_rd, commit_P_rd_new, commit_P_rd_old}, 32'd0);
    chk("rst_recovery", 32'(recovery), 32'd0);
    chk("rst_recovery_pc", recovery_pc, 32'd0);
    @(posedge clk); #1;
    rst = 1; mon_en = 1;

    // Fill all 16 entries with nothing completing.
    for (int i = 0; i < DEPTH; i++) begin
      set_alloc(i + 32, i, i + 64, 1'b1);
      smp();
      chk("fill_alloc_ready", 32'(alloc_ready), 32'd1);
      chk("fill_alloc_idx", 32'(alloc_idx), 32'(i));
      chk("fill_no_commit", 32'(commit_valid), 32'd0);
      nxt();
    end
    alloc_valid = 1;
    smp();
    chk("full_alloc_ready", 32'(alloc_ready), 32'd0);
    chk("full_no_commit", 32'(commit_valid), 32'd0);
    nxt();
    for (int i = 0; i < DEPTH; i++) begin
      wb_valid = 1; wb_idx = IW'(i);
      smp(); nxt();
    end
    drain();

    // Single instructions: allocate, write back, retire.
    for (int v = 0; v < 4; v++) begin
      set_alloc(int'(vecs[v].a), int'(vecs[v].pn), int'(vecs[v].po), vecs[v].we);
      ix = exp_tail % DEPTH;
      smp();
      chk("vec_alloc_no_commit", 32'(commit_valid), 32'd0);
      nxt();
      wb_valid = 1; wb_idx = IW'(ix);
      smp();
      chk("vec_wb_cycle_valid", 32'(commit_valid), 32'(BYP));
      chk("vec_wb_cycle_A_rd", 32'(commit_A_rd), 32'(BYP ? vecs[v].a : 6'd0));
      chk("vec_wb_cycle_wb_en", 32'(commit_wb_en), 32'(BYP ? vecs[v].exp_wb : 1'b0));
      nxt();
      smp();
      chk("vec_next_valid", 32'(commit_valid), 32'(!BYP));
      chk("vec_next_A_rd", 32'(commit_A_rd), 32'(!BYP ? vecs[v].a : 6'd0));
      chk("vec_next_P_new", 32'(commit_P_rd_new), 32'(!BYP ? vecs[v].pn : 7'd0));
      chk("vec_next_P_old", 32'(commit_P_rd_old), 32'(!BYP ? vecs[v].po : 7'd0));
      chk("vec_next_wb_en", 32'(commit_wb_en), 32'(!BYP ? vecs[v].exp_wb : 1'b0));
      nxt();
    end
    drain();

    // Out-of-order completion retires in program order.
    h0 = exp_tail;
    for (int i = 0; i < 3; i++) begin
      set_alloc(40 + i, 90 + i, 10 + i, 1'b1);
      smp(); nxt();
    end
    for (int i = 2; i >= 0; i--) begin
      wb_valid = 1; wb_idx = IW'((h0 + i) % DEPTH);
      smp();
      if (i > 0) chk("ooo_wait", 32'(commit_valid), 32'd0);
      else       chk("ooo_c0", 32'(commit_valid), 32'(BYP));
      nxt();
    end
    smp();
    chk("ooo_c1_valid", 32'(commit_valid), 32'd1);
    chk("ooo_c1_A_rd", 32'(commit_A_rd), BYP ? 32'd41 : 32'd40);
    nxt(); smp();
    chk("ooo_c2_valid", 32'(commit_valid), 32'd1);
    chk("ooo_c2_A_rd", 32'(commit_A_rd), BYP ? 32'd42 : 32'd41);
    nxt(); smp();
    chk("ooo_c3_valid", 32'(commit_valid), 32'(!BYP));
    nxt();
    drain();

    // Mispredicted branch in entry 1 flushes entries 2..4.
    h0 = exp_tail;
    exp_rpc = 32'h0000_1040;
    for (int i = 0; i < 5; i++) begin
      set_alloc(10 + i, 20 + i, 30 + i, 1'b1);
      smp(); nxt();
    end
    br_valid = 1; br_idx = IW'((h0 + 1) % DEPTH); br_mispredict = 1; br_target = 32'h0000_1040;
    wb_valid = 1; wb_idx = IW'((h0 + 2) % DEPTH);
    smp(); nxt();
    wb_valid = 1; wb_idx = IW'((h0 + 3) % DEPTH);
    smp(); nxt();
    wb_valid = 1; wb_idx = IW'((h0 + 4) % DEPTH);
    smp(); nxt();
    wb_valid = 1; wb_idx = IW'(h0 % DEPTH);
    c0 = commit_cnt;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      smp();
      if (recovery) begin seen = 1; break; end
      if (commit_valid && commit_A_rd == 6'd11) chk("flush_alloc_blocked", 32'(alloc_ready), 32'd0);
      nxt();
    end
    chk("mis_recovery_seen", 32'(seen), 32'd1);
    chk("mis_commits_before", 32'(commit_cnt - c0), 32'd2);
    chk("mis_recovery_pc", recovery_pc, 32'h0000_1040);
    chk("mis_commit_A_rd_zero", 32'(commit_A_rd), 32'd0);
    nxt(); smp();
    chk("post_rec_recovery", 32'(recovery), 32'd0);
    chk("post_rec_alloc_idx", 32'(alloc_idx), 32'((h0 + 2) % DEPTH));
    chk("post_rec_alloc_ready", 32'(alloc_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin nxt(); smp(); end
    chk("post_rec_no_commit", 32'(commit_cnt - c0), 32'd2);
    nxt();

    // Allocate and retire one per cycle across the pointer wrap.
    s  = exp_tail;
    c0 = commit_cnt;
    for (int c = 0; c < 42; c++) begin
      if (c < 40) set_alloc(c, c + 20, c, c[0]);
      if (c >= 1 && c <= 40) begin wb_valid = 1; wb_idx = IW'((s + c - 1) % DEPTH); end
      smp();
      if (c < 40) chk("stream_alloc_ready", 32'(alloc_ready), 32'd1);
      if (c >= 3 && c < 40) chk("stream_commit_valid", 32'(commit_valid), 32'd1);
      nxt();
    end
    drain();
    chk("stream_commit_count", 32'(commit_cnt - c0), 32'd40);

    // Reset while a mispredicted head is retiring: no recovery pulse follows.
    set_alloc(7, 8, 9, 1'b1);
    ix = exp_tail % DEPTH;
    smp(); nxt();
    br_valid = 1; br_idx = IW'(ix); br_mispredict = 1; br_target = 32'h0000_2000;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      smp();
      if (commit_valid) begin seen = 1; break; end
      nxt();
    end
    chk("rstmid_flush_reached", 32'(seen), 32'd1);
    rst = 0;
    #1;
    sb.delete(); exp_head = 0; exp_tail = 0;
    chk("rstmid_alloc_ready", 32'(alloc_ready), 32'd1);
    chk("rstmid_alloc_idx", 32'(alloc_idx), 32'd0);
    chk("rstmid_commit_valid", 32'(commit_valid), 32'd0);
    chk("rstmid_commit_wb_en", 32'(commit_wb_en), 32'd0);
    chk("rstmid_commit_fields", {13'd0, commit_A_rd, commit_P_rd_new, commit_P_rd_old}, 32'd0);
    chk("rstmid_recovery_pc", recovery_pc, 32'd0);
    nxt();
    chk("rstmid_recovery_in_rst", 32'(recovery), 32'd0);
    rst = 1;
    for (int k = 0; k < 3; k++) begin
      smp();
      chk("rstmid_no_recovery", 32'(recovery), 32'd0);
      chk("rstmid_idle_commit", 32'(commit_valid), 32'd0);
      nxt();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
REORDER_BUFFER -- requirements
Module: reorder_buffer

Interface
REQ-001 Parameter: DEPTH, default 16, number of ROB entries (power of two, matches free-list depth).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 alloc_valid  in  1  rename stage requests an entry this cycle.
REQ-005 alloc_ready  out  1  entry available; allocation occurs when alloc_valid && alloc_ready.
REQ-006 alloc_wb_en  in  1  instruction writes a destination (a physical register was taken from the free list).
REQ-007 alloc_A_rd / alloc_P_rd_new / alloc_P_rd_old  in  6/7/7  architectural rd, new physical rd, previous mapping.
REQ-008 alloc_idx  out  log2(DEPTH)  index assigned to the allocating instruction (equals tail).
REQ-009 wb_valid / wb_idx  in  1/log2(DEPTH)  execution complete for entry wb_idx.
REQ-010 br_valid / br_idx / br_mispredict / br_target  in  1/log2(DEPTH)/1/32  branch resolution; marks entry done, records mispredict and target.
REQ-011 commit_valid  out  1  head entry retires this cycle.
REQ-012 commit_wb_en  out  1  retiring entry has alloc_wb_en set; drives free-list head and CMT update.
REQ-013 commit_A_rd / commit_P_rd_new / commit_P_rd_old  out  6/7/7  fields of retiring entry; 0 when commit_valid is 0.
REQ-014 recovery / recovery_pc  out  1/32  registered flush pulse and redirect target.

Function
REQ-015 Circular buffer with head, tail pointers of log2(DEPTH)+1 bits (wrap bit); full when pointers differ only in wrap bit; empty when equal.
REQ-016 alloc_ready SHALL be !full && !recovery && !flush_pending; same-cycle commit does not free a slot for same-cycle allocation.
REQ-017 Allocation writes entry[tail] with valid=1, done=0, mispredict=0 and the alloc fields; tail increments modulo 2*DEPTH.
REQ-018 wb_valid sets done of entry wb_idx; br_valid sets done, mispredict=br_mispredict, target=br_target; writes to invalid entries are ignored.
REQ-019 Commit is combinational from the head: commit_valid = entry[head].valid && entry[head].done && !recovery; at most one commit per cycle.
REQ-020 On commit, entry[head].valid clears and head increments; commit_wb_en = commit_valid && entry.wb_en.
REQ-021 Committing an entry with mispredict=1 SHALL set flush_pending; in the next cycle recovery=1, recovery_pc=stored target, all commit outputs 0.
REQ-022 Recovery cycle: all entries invalidated, tail set to head, no allocation, wb/br inputs ignored; recovery deasserts the following cycle.
REQ-023 recovery is never asserted in the same cycle as commit_wb_en (rename free-list tail restore must see the final head).
REQ-024 Simultaneous allocate and commit on a non-full, non-empty buffer: both occur; occupancy unchanged.
REQ-025 Simultaneous wb to the head entry and commit evaluation: behaviour per REQ-031.
REQ-026 Pointer wrap: index DEPTH-1 followed by index 0; wrap bit toggles.

Reset
REQ-027 While rst is low: head=tail=0, all valid/done/mispredict=0, recovery=0, recovery_pc=0, flush_pending=0.
REQ-028 Reset outputs: alloc_ready=1, alloc_idx=0, commit_valid=0, commit_wb_en=0, commit fields=0.
REQ-029 Reset asserted mid-operation discards all entries immediately, including a pending recovery.

Configuration
REQ-030 Macro ROB_WB_BYPASS_EN selects head write-back bypass.
REQ-031 Defined: wb_valid or br_valid targeting the head entry counts as done in the same cycle, so it commits that cycle (br_mispredict then arms flush_pending). Undefined: done is seen only from the register; commit occurs one cycle after write-back.

Verification
REQ-032 Reset, allocate 16 entries with no write-back -> alloc_ready=0 after 16th, alloc_idx 0..15, no commit.
REQ-033 Allocate idx0 (A_rd=5, P_new=64, P_old=5, wb_en=1), wb idx0 -> commit_valid=1, commit_A_rd=5, P_rd_new=64, P_rd_old=5 (same cycle with bypass, next cycle without).
REQ-034 Out-of-order wb idx2, idx1, idx0 -> commits in order 0,1,2 on consecutive cycles.
REQ-035 Entry 1 br_mispredict=1, target=0x0000_1040, younger entries 2-4 done -> commit 0, commit 1, then recovery=1 with recovery_pc=0x1040, commit_valid=0; next cycle alloc_idx=2, entries 2-4 never commit.
REQ-036 Fill/drain 40 instructions with allocate+commit each cycle -> indices wrap 15->0, no loss, occupancy constant.
REQ-037 rst low during flush_pending -> recovery never pulses, all outputs at reset values.
